// File: rtl/des_iter_ctrl.sv
// Iterative DES engine: one Feistel round per clock, 16 rounds.
// Key schedule rotates C/D in place (left for encrypt, right for decrypt).
module des_iter_ctrl (
  input  logic        CLK,
  input  logic        RST,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic        MODE,
  input  logic [63:0] PLAIN_TEXT,
  input  logic [63:0] KEY,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [63:0] CIPHER_TEXT,
  output logic        BUSY,
  output logic [3:0]  ROUND_CNT
);

  localparam int IP_T [64] = '{
    58,50,42,34,26,18,10,2,60,52,44,36,28,20,12,4,
    62,54,46,38,30,22,14,6,64,56,48,40,32,24,16,8,
    57,49,41,33,25,17,9,1,59,51,43,35,27,19,11,3,
    61,53,45,37,29,21,13,5,63,55,47,39,31,23,15,7};
  localparam int FP_T [64] = '{
    40,8,48,16,56,24,64,32,39,7,47,15,55,23,63,31,
    38,6,46,14,54,22,62,30,37,5,45,13,53,21,61,29,
    36,4,44,12,52,20,60,28,35,3,43,11,51,19,59,27,
    34,2,42,10,50,18,58,26,33,1,41,9,49,17,57,25};
  localparam int E_T [48] = '{
    32,1,2,3,4,5,4,5,6,7,8,9,8,9,10,11,
    12,13,12,13,14,15,16,17,16,17,18,19,20,21,20,21,
    22,23,24,25,24,25,26,27,28,29,28,29,30,31,32,1};
  localparam int P_T [32] = '{
    16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,
    2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25};
  localparam int PC1_T [56] = '{
    57,49,41,33,25,17,9,1,58,50,42,34,26,18,
    10,2,59,51,43,35,27,19,11,3,60,52,44,36,
    63,55,47,39,31,23,15,7,62,54,46,38,30,22,
    14,6,61,53,45,37,29,21,13,5,28,20,12,4};
  localparam int PC2_T [48] = '{
    14,17,11,24,1,5,3,28,15,6,21,10,
    23,19,12,4,26,8,16,7,27,20,13,2,
    41,52,31,37,47,55,30,40,51,45,33,48,
    44,49,39,56,34,53,46,42,50,36,29,32};
  localparam logic [0:7][0:63][3:0] SB = {
    256'hE4D12FB83A6C59070F74E2D1A6CB953841E8D62BFC973A50FC8249175B3EA06D,
    256'hF18E6B34972DC05A3D47F28EC01A69B50E7BA4D158C6932FD8A13F42B67C05E9,
    256'hA09E63F51DC7B428D709346A285ECBF1D6498F30B12C5AE71AD069874FE3B52C,
    256'h7DE3069A1285BC4FD8B56F03472C1AE9A690CB7DF13E52843F06A1D8945BC72E,
    256'h2C417AB6853FD0E9EB2C47D150FA3986421BAD78F9C5630EB8C71E2D6F09A453,
    256'hC1AF92680D34E75BAF427C9561DE0B389EF528C3704A1DB6432C95FABE17608D,
    256'h4B2EF08D3C975A61D0B7491AE35C2F8614BDC37EAF6805926BD814A7950FE23C,
    256'hD2846FB1A93E50C71FD8A374C56B0E927B419CE206ADF35821E74A8DFC90356B};

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  state_t      state;
  logic [63:0] data;
  logic [27:0] c_q;
  logic [27:0] d_q;
  logic        mode_q;

  function automatic logic [63:0] ip(input logic [63:0] x);
    logic [63:0] o;
    for (int i = 0; i < 64; i++) o[6'(63-i)] = x[6'(64-IP_T[i])];
    return o;
  endfunction

  function automatic logic [63:0] fp(input logic [63:0] x);
    logic [63:0] o;
    for (int i = 0; i < 64; i++) o[6'(63-i)] = x[6'(64-FP_T[i])];
    return o;
  endfunction

  function automatic logic [55:0] pc1(input logic [63:0] x);
    logic [55:0] o;
    for (int i = 0; i < 56; i++) o[6'(55-i)] = x[6'(64-PC1_T[i])];
    return o;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] x);
    logic [47:0] o;
    for (int i = 0; i < 48; i++) o[6'(47-i)] = x[6'(56-PC2_T[i])];
    return o;
  endfunction

  function automatic logic [31:0] ffun(
    input logic [31:0] r,
    input logic [47:0] k
  );
    logic [47:0] x;
    logic [31:0] s;
    logic [31:0] o;
    logic [5:0]  b;
    for (int i = 0; i < 48; i++) x[6'(47-i)] = r[5'(32-E_T[i])];
    x = x ^ k;
    for (int j = 0; j < 8; j++) begin
      b = x[6'(47-6*j) -: 6];
      s[5'(31-4*j) -: 4] = SB[3'(j)][{b[5], b[0], b[4:1]}];
    end
    for (int i = 0; i < 32; i++) o[5'(31-i)] = s[5'(32-P_T[i])];
    return o;
  endfunction

  // Decrypt starts at K16 (no rotation), so its first step is 0.
  function automatic logic [1:0] shamt(
    input logic       dec,
    input logic [3:0] cnt
  );
    if (cnt == 4'd0) return dec ? 2'd0 : 2'd1;
    if (cnt == 4'd1 || cnt == 4'd8 || cnt == 4'd15) return 2'd1;
    return 2'd2;
  endfunction

  function automatic logic [27:0] rot(
    input logic [27:0] x,
    input logic        dec,
    input logic [1:0]  n
  );
    logic [27:0] o;
    o = x;
    if (dec) begin
      if (n == 2'd1) o = {x[0], x[27:1]};
      else if (n == 2'd2) o = {x[1:0], x[27:2]};
    end else begin
      if (n == 2'd1) o = {x[26:0], x[27]};
      else if (n == 2'd2) o = {x[25:0], x[27:26]};
    end
    return o;
  endfunction

  logic [1:0]  sh;
  logic [27:0] c_n;
  logic [27:0] d_n;
  logic [47:0] sub_key;
  logic [63:0] data_n;

  // Next key halves, round subkey and Feistel step for the current round.
  always_comb begin
    sh      = shamt(mode_q, ROUND_CNT);
    c_n     = rot(c_q, mode_q, sh);
    d_n     = rot(d_q, mode_q, sh);
    sub_key = pc2({c_n, d_n});
    data_n  = {data[31:0], data[63:32] ^ ffun(data[31:0], sub_key)};
  end

  assign IN_READY = (state == IDLE);
  assign BUSY     = (state == ROUND);

  // Control FSM with the datapath registers it owns.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      data        <= '0;
      c_q         <= '0;
      d_q         <= '0;
      mode_q      <= 1'b0;
      ROUND_CNT   <= '0;
      OUT_VALID   <= 1'b0;
      CIPHER_TEXT <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (IN_VALID) begin
            data         <= ip(PLAIN_TEXT);
            {c_q, d_q}   <= pc1(KEY);
            mode_q       <= MODE;
            ROUND_CNT    <= '0;
            state        <= ROUND;
          end
        end
        ROUND: begin
          data <= data_n;
          c_q  <= c_n;
          d_q  <= d_n;
          if (ROUND_CNT == 4'd15) begin
            CIPHER_TEXT <= fp({data_n[31:0], data_n[63:32]});
            OUT_VALID   <= 1'b1;
            ROUND_CNT   <= '0;
            state       <= DONE;
          end else begin
            ROUND_CNT <= ROUND_CNT + 4'd1;
          end
        end
        DONE: begin
          if (OUT_READY) begin
            OUT_VALID <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_des_iter_ctrl.sv
// Bench for des_iter_ctrl: reference DES with a precomputed
// key schedule, scoreboard queue filled on accept, drained on output.
module tb_des_iter_ctrl;

  localparam int IP_T [64] = '{
    58,50,42,34,26,18,10,2,60,52,44,36,28,20,12,4,
    62,54,46,38,30,22,14,6,64,56,48,40,32,24,16,8,
    57,49,41,33,25,17,9,1,59,51,43,35,27,19,11,3,
    61,53,45,37,29,21,13,5,63,55,47,39,31,23,15,7};
  localparam int FP_T [64] = '{
    40,8,48,16,56,24,64,32,39,7,47,15,55,23,63,31,
    38,6,46,14,54,22,62,30,37,5,45,13,53,21,61,29,
    36,4,44,12,52,20,60,28,35,3,43,11,51,19,59,27,
    34,2,42,10,50,18,58,26,33,1,41,9,49,17,57,25};
  localparam int E_T [48] = '{
    32,1,2,3,4,5,4,5,6,7,8,9,8,9,10,11,
    12,13,12,13,14,15,16,17,16,17,18,19,20,21,20,21,
    22,23,24,25,24,25,26,27,28,29,28,29,30,31,32,1};
  localparam int P_T [32] = '{
    16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,
    2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25};
  localparam int PC1_T [56] = '{
    57,49,41,33,25,17,9,1,58,50,42,34,26,18,
    10,2,59,51,43,35,27,19,11,3,60,52,44,36,
    63,55,47,39,31,23,15,7,62,54,46,38,30,22,
    14,6,61,53,45,37,29,21,13,5,28,20,12,4};
  localparam int PC2_T [48] = '{
    14,17,11,24,1,5,3,28,15,6,21,10,
    23,19,12,4,26,8,16,7,27,20,13,2,
    41,52,31,37,47,55,30,40,51,45,33,48,
    44,49,39,56,34,53,46,42,50,36,29,32};
  localparam int SH_T [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
  localparam logic [0:7][0:63][3:0] SB = {
    256'hE4D12FB83A6C59070F74E2D1A6CB953841E8D62BFC973A50FC8249175B3EA06D,
    256'hF18E6B34972DC05A3D47F28EC01A69B50E7BA4D158C6932FD8A13F42B67C05E9,
    256'hA09E63F51DC7B428D709346A285ECBF1D6498F30B12C5AE71AD069874FE3B52C,
    256'h7DE3069A1285BC4FD8B56F03472C1AE9A690CB7DF13E52843F06A1D8945BC72E,
    256'h2C417AB6853FD0E9EB2C47D150FA3986421BAD78F9C5630EB8C71E2D6F09A453,
    256'hC1AF92680D34E75BAF427C9561DE0B389EF528C3704A1DB6432C95FABE17608D,
    256'h4B2EF08D3C975A61D0B7491AE35C2F8614BDC37EAF6805926BD814A7950FE23C,
    256'hD2846FB1A93E50C71FD8A374C56B0E927B419CE206ADF35821E74A8DFC90356B};

  localparam logic [63:0] K0 = 64'h133457799BBCDFF1;
  localparam logic [63:0] P0 = 64'h0123456789ABCDEF;
  localparam logic [63:0] C0 = 64'h85E813540F0AB405;

  logic        CLK = 1'b0;
  logic        RST;
  logic        IN_VALID;
  logic        IN_READY;
  logic        MODE;
  logic [63:0] PLAIN_TEXT;
  logic [63:0] KEY;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [63:0] CIPHER_TEXT;
  logic        BUSY;
  logic [3:0]  ROUND_CNT;

  des_iter_ctrl dut (
    .CLK(CLK), .RST(RST),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .MODE(MODE), .PLAIN_TEXT(PLAIN_TEXT), .KEY(KEY),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .CIPHER_TEXT(CIPHER_TEXT),
    .BUSY(BUSY), .ROUND_CNT(ROUND_CNT)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc++;

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [63:0] exp_q [$];
  int          acc_cyc = 0;
  int          n_acc   = 0;
  int          n_out   = 0;
  bit          prev_ov = 1'b0;
  bit          b2b     = 1'b0;
  logic [63:0] last_out = '0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] f_model(logic [31:0] r, logic [47:0] k);
    logic [47:0] x;
    logic [31:0] s;
    logic [31:0] o;
    logic [5:0]  b;
    int          idx;
    for (int i = 0; i < 48; i++) x[6'(47-i)] = r[5'(32-E_T[i])];
    x = x ^ k;
    for (int j = 0; j < 8; j++) begin
      b   = x[6'(47-6*j) -: 6];
      idx = 32 * int'(b[5]) + 16 * int'(b[0]) + int'(b[4:1]);
      s[5'(31-4*j) -: 4] = SB[3'(j)][6'(idx)];
    end
    for (int i = 0; i < 32; i++) o[5'(31-i)] = s[5'(32-P_T[i])];
    return o;
  endfunction

  function automatic logic [63:0] des_model(
    logic [63:0] key, logic [63:0] blk, logic dec
  );
    logic [55:0] cd;
    logic [27:0] c, d;
    logic [47:0] ks [16];
    logic [63:0] t, o;
    logic [31:0] l, r, tmp;
    for (int i = 0; i < 56; i++) cd[6'(55-i)] = key[6'(64-PC1_T[i])];
    c = cd[55:28];
    d = cd[27:0];
    for (int n = 0; n < 16; n++) begin
      for (int s = 0; s < SH_T[n]; s++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      cd = {c, d};
      for (int i = 0; i < 48; i++) ks[n][6'(47-i)] = cd[6'(56-PC2_T[i])];
    end
    for (int i = 0; i < 64; i++) t[6'(63-i)] = blk[6'(64-IP_T[i])];
    l = t[63:32];
    r = t[31:0];
    for (int n = 0; n < 16; n++) begin
      tmp = l ^ f_model(r, dec ? ks[15-n] : ks[n]);
      l   = r;
      r   = tmp;
    end
    t = {r, l};
    for (int i = 0; i < 64; i++) o[6'(63-i)] = t[6'(64-FP_T[i])];
    return o;
  endfunction

  // Scoreboard: push on accept, pop/compare on output handshake.
  always @(negedge CLK) begin
    if (!RST && IN_VALID && IN_READY) begin
      exp_q.push_back(des_model(KEY, PLAIN_TEXT, MODE));
      if (b2b && n_acc > 0)
        chk("b2b_gap", 64'(cyc + 1 - acc_cyc), 64'd18);
      acc_cyc = cyc + 1;
      n_acc++;
    end
    if (OUT_VALID && !prev_ov)
      chk("latency", 64'(cyc - acc_cyc), 64'd16);
    prev_ov = OUT_VALID;
    if (!RST && OUT_VALID && OUT_READY) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out", 64'(OUT_VALID), 64'd0);
      end else begin
        chk("result", CIPHER_TEXT, exp_q.pop_front());
        last_out = CIPHER_TEXT;
        n_out++;
      end
    end
  end

  task automatic send(logic [63:0] k, logic [63:0] b, logic m);
    @(posedge CLK); #1;
    KEY = k; PLAIN_TEXT = b; MODE = m; IN_VALID = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      if (IN_READY) begin
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
        return;
      end
    end
    chk("send_timeout", 64'(IN_READY), 64'd1);
    IN_VALID = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      if (exp_q.size() == 0 && IN_READY) return;
    end
    chk("done_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog cycles=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] k, x, c;
    int          base;
    RST = 1'b1; IN_VALID = 1'b0; MODE = 1'b0;
    PLAIN_TEXT = '0; KEY = '0; OUT_READY = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_ov", 64'(OUT_VALID), 64'd0);
    chk("rst_ct", CIPHER_TEXT, 64'd0);
    chk("rst_busy", 64'(BUSY), 64'd0);
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    chk("rst_inready", 64'(IN_READY), 64'd1);
    chk("rst_cnt", 64'(ROUND_CNT), 64'd0);

    // Known-answer encrypt and decrypt.
    send(K0, P0, 1'b0);
    @(negedge CLK);
    chk("busy_round", 64'(BUSY), 64'd1);
    chk("inready_round", 64'(IN_READY), 64'd0);
    wait_done();
    chk("kat_enc", last_out, C0);
    send(K0, C0, 1'b1);
    wait_done();
    chk("kat_dec", last_out, P0);

    // Backpressure: result held, new requests ignored.
    @(posedge CLK); #1;
    OUT_READY = 1'b0;
    send(K0, P0, 1'b0);
    for (int i = 0; i < 40 && !OUT_VALID; i++) @(negedge CLK);
    chk("bp_rise", 64'(OUT_VALID), 64'd1);
    for (int i = 0; i < 10; i++) begin
      @(posedge CLK); #1;
      IN_VALID = 1'b1;
      PLAIN_TEXT = {$urandom, $urandom};
      @(negedge CLK);
      chk("bp_valid", 64'(OUT_VALID), 64'd1);
      chk("bp_data", CIPHER_TEXT, C0);
      chk("bp_inready", 64'(IN_READY), 64'd0);
    end
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    OUT_READY = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    chk("bp_idle", 64'(IN_READY), 64'd1);
    chk("bp_ov_low", 64'(OUT_VALID), 64'd0);
    chk("bp_q", 64'(exp_q.size()), 64'd0);

    // Reset in the middle of round 7.
    send(K0, P0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (BUSY && ROUND_CNT == 4'd7) break;
    end
    chk("mid_cnt", 64'(ROUND_CNT), 64'd7);
    RST = 1'b1;
    exp_q.delete();
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    chk("mid_inready", 64'(IN_READY), 64'd1);
    chk("mid_busy", 64'(BUSY), 64'd0);
    chk("mid_ov", 64'(OUT_VALID), 64'd0);
    chk("mid_ct", CIPHER_TEXT, 64'd0);
    chk("mid_cnt0", 64'(ROUND_CNT), 64'd0);
    repeat (20) @(negedge CLK);
    chk("mid_no_out", 64'(OUT_VALID), 64'd0);
    send(K0, C0, 1'b1);
    wait_done();
    chk("post_rst", last_out, P0);

    // Back-to-back with IN_VALID held high.
    base = n_out;
    n_acc = 0;
    b2b = 1'b1;
    @(posedge CLK); #1;
    KEY = {$urandom, $urandom};
    PLAIN_TEXT = {$urandom, $urandom};
    MODE = 1'b0;
    IN_VALID = 1'b1;
    for (int i = 0; i < 100 && n_acc < 3; i++) @(negedge CLK);
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    wait_done();
    b2b = 1'b0;
    chk("b2b_count", 64'(n_out - base), 64'd3);

    // Random round trips through the DUT in both modes.
    for (int i = 0; i < 1000; i++) begin
      k = {$urandom, $urandom};
      x = {$urandom, $urandom};
      send(k, x, 1'b0);
      wait_done();
      c = last_out;
      send(k, c, 1'b1);
      wait_done();
      chk("roundtrip", last_out, x);
    end

    chk("final_q", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/des_iter_ctrl.md
DES_ITER_CTRL -- requirements
Module: des_iter_ctrl

Interface
REQ-001 Parameter: none; round count fixed at 16, iterative engine, one round per clock.
REQ-002 Clock and reset: one clock; reset is synchronous and active-high.
REQ-003 CLK  input  1  rising-edge clock for all state.
REQ-004 RST  input  1  synchronous active-high reset.
REQ-005 IN_VALID  input  1  request carries valid PLAIN_TEXT/KEY/MODE.
REQ-006 IN_READY  output  1  controller accepts a request this cycle.
REQ-007 MODE  input  1  0 = encrypt, 1 = decrypt; sampled at accept.
REQ-008 PLAIN_TEXT  input  64  input block (ciphertext when MODE=1); sampled at accept.
REQ-009 KEY  input  64  DES key with parity bits; sampled at accept.
REQ-010 OUT_VALID  output  1  CIPHER_TEXT holds a finished result.
REQ-011 OUT_READY  input  1  consumer takes result when OUT_VALID=1.
REQ-012 CIPHER_TEXT  output  64  result block (plaintext when MODE=1).
REQ-013 BUSY  output  1  high in LOAD-free ROUND state only.
REQ-014 ROUND_CNT  output  4  index of the round being applied, 0..15.

Function
REQ-015 FSM states: IDLE, ROUND, DONE; encoding free.
REQ-016 IN_READY SHALL be 1 exactly in IDLE; no overlap of requests.
REQ-017 Accept = IN_VALID & IN_READY; on accept: data reg <= IP(PLAIN_TEXT) via init, C/D regs <= PC-1(KEY) (28+28 bits), mode reg <= MODE, ROUND_CNT <= 0, state -> ROUND.
REQ-018 IN_VALID with IN_READY=0 SHALL be ignored without side effects.
REQ-019 In ROUND, each cycle: data reg <= DES_round(data reg, PC-2(C',D')), C/D <= C',D', ROUND_CNT += 1.
REQ-020 Encrypt: C',D' = C,D each rotated left by s[ROUND_CNT], s = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
REQ-021 Decrypt: C',D' = C,D each rotated right by r[ROUND_CNT], r = 0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
REQ-022 Rotation applies to each 28-bit half independently; no carry between halves.
REQ-023 On the cycle ROUND_CNT=15: after the round update, CIPHER_TEXT <= final_perm(new data), OUT_VALID <= 1, ROUND_CNT <= 0, state -> DONE.
REQ-024 Latency: OUT_VALID rises exactly 16 clocks after the accept edge.
REQ-025 Round/swap semantics identical to the team's 16-stage combinational DES_top; encrypt result SHALL bit-match DES_top for equal inputs.
REQ-026 DONE: CIPHER_TEXT and OUT_VALID held stable until OUT_READY=1; on that edge OUT_VALID <= 0, state -> IDLE.
REQ-027 OUT_READY outside DONE SHALL be ignored.
REQ-028 CIPHER_TEXT SHALL not change except on the REQ-023 edge or reset.
REQ-029 BUSY = (state == ROUND).

Reset
REQ-030 RST=1 at any clock edge, any state: state -> IDLE, OUT_VALID=0, CIPHER_TEXT=0, ROUND_CNT=0, data/C/D/mode regs=0; in-flight operation discarded, no OUT_VALID pulse produced.
REQ-031 RST has priority over accept and OUT_READY in the same cycle.
REQ-032 After reset, IN_READY=1 on the first non-reset cycle.

Verification
REQ-033 Encrypt KEY=133457799BBCDFF1, PT=0123456789ABCDEF, OUT_READY=1 -> OUT_VALID rises 16 clocks after accept, CIPHER_TEXT=85E813540F0AB405.
REQ-034 Decrypt same KEY, input 85E813540F0AB405, MODE=1 -> CIPHER_TEXT=0123456789ABCDEF after 16 clocks.
REQ-035 Backpressure: OUT_READY=0 for 10 cycles after OUT_VALID -> result/valid stable, IN_READY=0, new IN_VALID ignored; OUT_READY=1 -> IDLE next cycle.
REQ-036 RST asserted at ROUND_CNT=7 -> next cycle IDLE, all outputs 0, no result; following request completes correctly.
REQ-037 IN_VALID held high continuously with OUT_READY=1 -> back-to-back operations, one accept per 18 cycles (accept, 15 more ROUND, DONE, IDLE), no lost or duplicated results.
REQ-038 Random 1000 keys/blocks, both modes -> encrypt matches DES_top model; decrypt(encrypt(x)) = x.
